exe_stage: RTL and testbench

- Execute stage of the 5-stage ARM-subset pipeline. Sits directly downstream of the ID/EX pipeline register and consumes all of its outputs.
- Contains the operand forwarding muxes, the Val2 generator, the ALU and the branch-target adder.
- Owns the architectural NZCV status register, which feeds the ID condition check.
- Includes the EX/MEM pipeline register feeding the MEM stage.

---
 rtl/exe_stage_if.sv | 59 +++++
 rtl/exe_stage.sv | 181 ++++++++++++++++++
 tb/tb_exe_stage.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage_if
// Brief    : ID/EX-to-EX/MEM bundle for the execute stage (controls, operands,
//            forwarding inputs, branch and registered outputs).
// Revision : 1.0
// ============================================================================
interface exe_stage_if #(
  parameter int WIDTH = 32
);
  logic             freeze;
  logic             WB_EN_In;
  logic             MEM_R_EN_In;
  logic             MEM_W_EN_In;
  logic             B_In;
  logic             S_In;
  logic [3:0]       EXE_CMD_In;
  logic [WIDTH-1:0] PC_In;
  logic [WIDTH-1:0] Val_Rn_In;
  logic [WIDTH-1:0] Val_Rm_In;
  logic             imm_In;
  logic [11:0]      Shift_operand_In;
  logic [23:0]      Signed_imm_24_In;
  logic [3:0]       Dest_In;
  logic [3:0]       SR_In;
  logic [1:0]       sel_src1;
  logic [1:0]       sel_src2;
  logic [WIDTH-1:0] MEM_ALU_Res;
  logic [WIDTH-1:0] WB_Value;

  logic             Branch_Taken;
  logic [WIDTH-1:0] Branch_Address;
  logic [3:0]       SR;
  logic             WB_EN_Out;
  logic             MEM_R_EN_Out;
  logic             MEM_W_EN_Out;
  logic [WIDTH-1:0] ALU_Res_Out;
  logic [WIDTH-1:0] Val_Rm_Out;
  logic [3:0]       Dest_Out;

  modport master (
    output freeze, WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, EXE_CMD_In,
           PC_In, Val_Rn_In, Val_Rm_In, imm_In, Shift_operand_In,
           Signed_imm_24_In, Dest_In, SR_In, sel_src1, sel_src2,
           MEM_ALU_Res, WB_Value,
    input  Branch_Taken, Branch_Address, SR, WB_EN_Out, MEM_R_EN_Out,
           MEM_W_EN_Out, ALU_Res_Out, Val_Rm_Out, Dest_Out
  );

  modport slave (
    input  freeze, WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, EXE_CMD_In,
           PC_In, Val_Rn_In, Val_Rm_In, imm_In, Shift_operand_In,
           Signed_imm_24_In, Dest_In, SR_In, sel_src1, sel_src2,
           MEM_ALU_Res, WB_Value,
    output Branch_Taken, Branch_Address, SR, WB_EN_Out, MEM_R_EN_Out,
           MEM_W_EN_Out, ALU_Res_Out, Val_Rm_Out, Dest_Out
  );
endinterface
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage
// Brief    : ARM-subset execute stage: forwarding, Val2 shifter, ALU, NZCV
//            status register, branch-target adder and EX/MEM register.
// Revision : 1.0
// ============================================================================
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic       CLK,
  input  logic       RST,
  exe_stage_if.slave bus
);

  localparam logic [3:0] c_cmd_mov = 4'b0001;
  localparam logic [3:0] c_cmd_mvn = 4'b1001;
  localparam logic [3:0] c_cmd_add = 4'b0010;
  localparam logic [3:0] c_cmd_adc = 4'b0011;
  localparam logic [3:0] c_cmd_sub = 4'b0100;
  localparam logic [3:0] c_cmd_sbc = 4'b0101;
  localparam logic [3:0] c_cmd_and = 4'b0110;
  localparam logic [3:0] c_cmd_orr = 4'b0111;
  localparam logic [3:0] c_cmd_eor = 4'b1000;

  localparam logic [1:0] c_sel_mem = 2'b01;
  localparam logic [1:0] c_sel_wb  = 2'b10;

  localparam logic [1:0] c_sh_lsl = 2'b00;
  localparam logic [1:0] c_sh_lsr = 2'b01;
  localparam logic [1:0] c_sh_asr = 2'b10;

  // A left shift by WIDTH yields zero, so amt=0 falls out as a pass-through.
  function automatic logic [WIDTH-1:0] f_ror(input logic [WIDTH-1:0] x,
                                             input logic [4:0]       amt);
    return (x >> amt) | (x << (6'(WIDTH) - {1'b0, amt}));
  endfunction

  logic [WIDTH-1:0] w_src1;
  logic [WIDTH-1:0] w_frm;
  logic [4:0]       w_rot_amt;
  logic [4:0]       w_sh_amt;
  logic [WIDTH-1:0] w_imm_zx;
  logic [WIDTH-1:0] w_val2;
  logic             w_is_arith;
  logic [WIDTH-1:0] w_addend;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_cmd_valid;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_overflow;
  logic [3:0]       w_flags;
  logic [WIDTH-1:0] w_br_offset;

  logic [3:0]       sr_q, sr_d;
  logic             wb_en_q, mem_r_en_q, mem_w_en_q;
  logic [WIDTH-1:0] alu_res_q;
  logic [WIDTH-1:0] val_rm_q;
  logic [3:0]       dest_q;

  always_comb begin
    case (bus.sel_src1)
      c_sel_mem: w_src1 = bus.MEM_ALU_Res;
      c_sel_wb:  w_src1 = bus.WB_Value;
      default:   w_src1 = bus.Val_Rn_In;
    endcase
  end

  always_comb begin
    case (bus.sel_src2)
      c_sel_mem: w_frm = bus.MEM_ALU_Res;
      c_sel_wb:  w_frm = bus.WB_Value;
      default:   w_frm = bus.Val_Rm_In;
    endcase
  end

  assign w_rot_amt = {bus.Shift_operand_In[11:8], 1'b0};
  assign w_sh_amt  = bus.Shift_operand_In[11:7];
  assign w_imm_zx  = {{(WIDTH-8){1'b0}}, bus.Shift_operand_In[7:0]};

  always_comb begin
    w_val2 = w_frm;
    if (bus.imm_In) begin
      w_val2 = f_ror(w_imm_zx, w_rot_amt);
    end else if (bus.MEM_R_EN_In || bus.MEM_W_EN_In) begin
      w_val2 = {{(WIDTH-12){1'b0}}, bus.Shift_operand_In};
    end else begin
      case (bus.Shift_operand_In[6:5])
        c_sh_lsl: w_val2 = w_frm << w_sh_amt;
        c_sh_lsr: w_val2 = w_frm >> w_sh_amt;
        c_sh_asr: w_val2 = $unsigned($signed(w_frm) >>> w_sh_amt);
        default:  w_val2 = f_ror(w_frm, w_sh_amt);
      endcase
    end
  end

  // Subtraction is a + ~b + cin, so the adder carry-out is already NOT borrow.
  always_comb begin
    w_is_arith = 1'b1;
    w_addend   = w_val2;
    w_cin      = 1'b0;
    case (bus.EXE_CMD_In)
      c_cmd_add: begin end
      c_cmd_adc: w_cin = bus.SR_In[1];
      c_cmd_sub: begin
        w_addend = ~w_val2;
        w_cin    = 1'b1;
      end
      c_cmd_sbc: begin
        w_addend = ~w_val2;
        w_cin    = bus.SR_In[1];
      end
      default:   w_is_arith = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, w_src1} + {1'b0, w_addend} + {{WIDTH{1'b0}}, w_cin};

  always_comb begin
    w_cmd_valid = 1'b1;
    w_alu_res   = '0;
    case (bus.EXE_CMD_In)
      c_cmd_mov: w_alu_res = w_val2;
      c_cmd_mvn: w_alu_res = ~w_val2;
      c_cmd_add,
      c_cmd_adc,
      c_cmd_sub,
      c_cmd_sbc: w_alu_res = w_sum[WIDTH-1:0];
      c_cmd_and: w_alu_res = w_src1 & w_val2;
      c_cmd_orr: w_alu_res = w_src1 | w_val2;
      c_cmd_eor: w_alu_res = w_src1 ^ w_val2;
      default:   w_cmd_valid = 1'b0;
    endcase
  end

  assign w_overflow = (w_src1[WIDTH-1] == w_addend[WIDTH-1]) &&
                      (w_alu_res[WIDTH-1] != w_src1[WIDTH-1]);

  assign w_flags = {w_alu_res[WIDTH-1],
                    (w_alu_res == '0),
                    w_is_arith ? w_sum[WIDTH] : bus.SR_In[1],
                    w_is_arith ? w_overflow   : bus.SR_In[0]};

  // Unrecognised opcodes leave the status register untouched even with S set.
  assign sr_d = (bus.S_In && w_cmd_valid) ? w_flags : sr_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_q       <= 4'b0000;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= '0;
      val_rm_q   <= '0;
      dest_q     <= 4'b0000;
    end else if (!bus.freeze) begin
      sr_q       <= sr_d;
      wb_en_q    <= bus.WB_EN_In;
      mem_r_en_q <= bus.MEM_R_EN_In;
      mem_w_en_q <= bus.MEM_W_EN_In;
      alu_res_q  <= w_alu_res;
      val_rm_q   <= w_frm;
      dest_q     <= bus.Dest_In;
    end
  end

  assign w_br_offset = {{(WIDTH-26){bus.Signed_imm_24_In[23]}},
                        bus.Signed_imm_24_In, 2'b00};

  assign bus.Branch_Taken   = bus.B_In;
  assign bus.Branch_Address = bus.PC_In + w_br_offset;
  assign bus.SR             = sr_q;
  assign bus.WB_EN_Out      = wb_en_q;
  assign bus.MEM_R_EN_Out   = mem_r_en_q;
  assign bus.MEM_W_EN_Out   = mem_w_en_q;
  assign bus.ALU_Res_Out    = alu_res_q;
  assign bus.Val_Rm_Out     = val_rm_q;
  assign bus.Dest_Out       = dest_q;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_stage
// Brief    : Directed and randomized bench for exe_stage against an
//            arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_exe_stage;

  localparam longint c_max_s = 64'sh7FFF_FFFF;
  localparam longint c_min_s = -64'sh8000_0000;

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [3:0]  m_sr;
  logic [2:0]  m_ctl;
  logic [31:0] m_res;
  logic [31:0] m_rm;
  logic [3:0]  m_dest;

  always #5 CLK = ~CLK;

  exe_stage_if #(.WIDTH(32)) ifc ();

  exe_stage #(.WIDTH(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] reg_v,
                                          input logic [31:0] mem_v, input logic [31:0] wb_v);
    case (sel)
      2'b01:   return mem_v;
      2'b10:   return wb_v;
      default: return reg_v;
    endcase
  endfunction

  function automatic logic [31:0] ref_val2(input logic imm, input logic [11:0] so,
                                           input logic memop, input logic [31:0] x);
    int     amt;
    longint s;
    if (imm) return ref_ror({24'd0, so[7:0]}, 2 * int'(so[11:8]));
    if (memop) return {20'd0, so};
    amt = int'(so[11:7]);
    s   = longint'($signed(x));
    case (so[6:5])
      2'b00:   return 32'(64'(x) << amt);
      2'b01:   return x >> amt;
      2'b10:   return 32'(s >>> amt);
      default: return ref_ror(x, amt);
    endcase
  endfunction

  task automatic ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sr_in, output logic [31:0] res,
                         output logic [3:0] nzcv, output logic valid);
    longint unsigned ua, ub, cin, borrow;
    longint          sa, sb, sres;
    logic            c, v;
    ua = a; ub = b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cin = sr_in[1];
    borrow = 1 - cin;
    c = sr_in[1]; v = sr_in[0]; valid = 1'b1; sres = 0;
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd2: begin res = 32'(ua + ub);       c = (ua + ub) > 64'hFFFF_FFFF;       sres = sa + sb; end
      4'd3: begin res = 32'(ua + ub + cin); c = (ua + ub + cin) > 64'hFFFF_FFFF; sres = sa + sb + longint'(cin); end
      4'd4: begin res = 32'(ua - ub);          c = ua >= ub;          sres = sa - sb; end
      4'd5: begin res = 32'(ua - ub - borrow); c = ua >= ub + borrow; sres = sa - sb - longint'(borrow); end
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      default: begin res = 32'd0; valid = 1'b0; end
    endcase
    if (cmd inside {4'd2, 4'd3, 4'd4, 4'd5}) v = (sres > c_max_s) || (sres < c_min_s);
    nzcv = {res[31], res == 32'd0, c, v};
  endtask

  task automatic idle();
    ifc.freeze = 0; ifc.WB_EN_In = 0; ifc.MEM_R_EN_In = 0; ifc.MEM_W_EN_In = 0;
    ifc.B_In = 0; ifc.S_In = 0; ifc.EXE_CMD_In = 0; ifc.PC_In = 0;
    ifc.Val_Rn_In = 0; ifc.Val_Rm_In = 0; ifc.imm_In = 0; ifc.Shift_operand_In = 0;
    ifc.Signed_imm_24_In = 0; ifc.Dest_In = 0; ifc.SR_In = 0;
    ifc.sel_src1 = 0; ifc.sel_src2 = 0; ifc.MEM_ALU_Res = 0; ifc.WB_Value = 0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic drive_random();
    ifc.freeze = ($urandom_range(0, 4) == 0);
    ifc.WB_EN_In = 1'($urandom()); ifc.MEM_R_EN_In = 1'($urandom());
    ifc.MEM_W_EN_In = 1'($urandom()); ifc.B_In = 1'($urandom()); ifc.S_In = 1'($urandom());
    ifc.EXE_CMD_In = 4'($urandom()); ifc.PC_In = $urandom();
    ifc.Val_Rn_In = pick_val(); ifc.Val_Rm_In = pick_val(); ifc.imm_In = 1'($urandom());
    ifc.Shift_operand_In = 12'($urandom()); ifc.Signed_imm_24_In = 24'($urandom());
    ifc.Dest_In = 4'($urandom()); ifc.SR_In = 4'($urandom());
    ifc.sel_src1 = 2'($urandom()); ifc.sel_src2 = 2'($urandom());
    ifc.MEM_ALU_Res = pick_val(); ifc.WB_Value = pick_val();
  endtask

  task automatic reset_model();
    m_sr = 0; m_ctl = 0; m_res = 0; m_rm = 0; m_dest = 0;
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, "_sr"},   {28'd0, ifc.SR}, {28'd0, m_sr});
    check_eq({tag, "_ctl"},  {29'd0, ifc.WB_EN_Out, ifc.MEM_R_EN_Out, ifc.MEM_W_EN_Out}, {29'd0, m_ctl});
    check_eq({tag, "_res"},  ifc.ALU_Res_Out, m_res);
    check_eq({tag, "_rm"},   ifc.Val_Rm_Out, m_rm);
    check_eq({tag, "_dest"}, {28'd0, ifc.Dest_Out}, {28'd0, m_dest});
  endtask

  // Evaluates one instruction on the model, advances one edge and compares.
  task automatic tick();
    logic [31:0] e_baddr, f1, f2, v2, res;
    logic [3:0]  fl;
    logic        vld;
    #1;
    e_baddr = ifc.PC_In + 32'(longint'($signed(ifc.Signed_imm_24_In)) * 4);
    check_eq("br_taken", {31'd0, ifc.Branch_Taken}, {31'd0, ifc.B_In});
    check_eq("br_addr", ifc.Branch_Address, e_baddr);
    f1 = ref_fwd(ifc.sel_src1, ifc.Val_Rn_In, ifc.MEM_ALU_Res, ifc.WB_Value);
    f2 = ref_fwd(ifc.sel_src2, ifc.Val_Rm_In, ifc.MEM_ALU_Res, ifc.WB_Value);
    v2 = ref_val2(ifc.imm_In, ifc.Shift_operand_In, ifc.MEM_R_EN_In | ifc.MEM_W_EN_In, f2);
    ref_alu(ifc.EXE_CMD_In, f1, v2, ifc.SR_In, res, fl, vld);
    if (!ifc.freeze) begin
      m_res = res; m_rm = f2; m_dest = ifc.Dest_In;
      m_ctl = {ifc.WB_EN_In, ifc.MEM_R_EN_In, ifc.MEM_W_EN_In};
      if (ifc.S_In && vld) m_sr = fl;
    end
    @(posedge CLK);
    #1;
    check_regs("reg");
  endtask

  initial begin
    RST = 1'b1;
    idle();
    reset_model();
    #12;
    check_regs("rst");
    RST = 1'b0;

    // ADDS overflow
    idle(); ifc.Val_Rn_In = 32'h7FFF_FFFF; ifc.imm_In = 1; ifc.Shift_operand_In = 12'h001;
    ifc.EXE_CMD_In = 4'b0010; ifc.S_In = 1; ifc.WB_EN_In = 1; ifc.Dest_In = 4'd3;
    tick();
    check_eq("adds_res", ifc.ALU_Res_Out, 32'h8000_0000);
    check_eq("adds_sr", {28'd0, ifc.SR}, 32'b1001);

    // SUBS equal then SBC with C clear
    idle(); ifc.Val_Rn_In = 5; ifc.Val_Rm_In = 5; ifc.EXE_CMD_In = 4'b0100; ifc.S_In = 1;
    tick();
    check_eq("subs_res", ifc.ALU_Res_Out, 32'd0);
    check_eq("subs_sr", {28'd0, ifc.SR}, 32'b0110);
    idle(); ifc.Val_Rn_In = 5; ifc.Val_Rm_In = 3; ifc.EXE_CMD_In = 4'b0101; ifc.SR_In = 4'b0000;
    tick();
    check_eq("sbc_res", ifc.ALU_Res_Out, 32'd1);

    // Shifter and rotated immediates
    idle(); ifc.Val_Rm_In = 32'h8000_0001; ifc.Shift_operand_In = 12'h0C0; ifc.EXE_CMD_In = 4'b0001;
    tick();
    check_eq("asr1", ifc.ALU_Res_Out, 32'hC000_0000);
    ifc.Shift_operand_In = 12'h260;
    tick();
    check_eq("ror4", ifc.ALU_Res_Out, 32'h1800_0000);
    idle(); ifc.imm_In = 1; ifc.Shift_operand_In = 12'h4FF; ifc.EXE_CMD_In = 4'b0001;
    tick();
    check_eq("imm_rot", ifc.ALU_Res_Out, 32'hFF00_0000);

    // Branch target, visible before the edge
    idle(); ifc.B_In = 1; ifc.PC_In = 32'h100; ifc.Signed_imm_24_In = 24'hFF_FFFE;
    #1;
    check_eq("br_dir_taken", {31'd0, ifc.Branch_Taken}, 32'd1);
    check_eq("br_dir_addr", ifc.Branch_Address, 32'h0F8);
    tick();

    // Forwarding
    idle(); ifc.sel_src1 = 2'b01; ifc.MEM_ALU_Res = 7; ifc.Val_Rn_In = 99;
    ifc.imm_In = 1; ifc.Shift_operand_In = 12'h003; ifc.EXE_CMD_In = 4'b0010;
    tick();
    check_eq("fwd_mem", ifc.ALU_Res_Out, 32'd10);
    idle(); ifc.MEM_W_EN_In = 1; ifc.sel_src2 = 2'b10; ifc.WB_Value = 32'hAB; ifc.Val_Rm_In = 32'h55;
    ifc.Val_Rn_In = 32'h1000; ifc.Shift_operand_In = 12'h004; ifc.EXE_CMD_In = 4'b0010; ifc.Dest_In = 4'd2;
    tick();
    check_eq("str_rm", ifc.Val_Rm_Out, 32'hAB);
    check_eq("str_addr", ifc.ALU_Res_Out, 32'h1004);

    // Freeze holds EX/MEM and SR; the S update lands once the stall clears
    idle(); ifc.freeze = 1; ifc.S_In = 1; ifc.Val_Rn_In = 32'hFFFF_FFFF; ifc.imm_In = 1;
    ifc.Shift_operand_In = 12'h002; ifc.EXE_CMD_In = 4'b0010; ifc.WB_EN_In = 1; ifc.Dest_In = 4'd9;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("frz_res", ifc.ALU_Res_Out, 32'h1004);
      check_eq("frz_sr", {28'd0, ifc.SR}, 32'b0110);
    end
    ifc.freeze = 0;
    tick();
    check_eq("unfrz_res", ifc.ALU_Res_Out, 32'd1);
    check_eq("unfrz_sr", {28'd0, ifc.SR}, 32'b0010);

    for (int i = 0; i < 400; i++) begin
      drive_random();
      tick();
    end

    // Asynchronous reset in the middle of a cycle, under freeze
    ifc.freeze = 1;
    #2;
    RST = 1'b1;
    #1;
    reset_model();
    check_regs("mid_rst");
    #2;
    RST = 1'b0;
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
